// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: PS/2 device-to-host receiver (11-bit frame, odd parity) with a glitch filter and a stall timeout.
// Emits one scan_ready pulse per good frame and one frame_err pulse per dropped frame.
module ps2_rx_ctrl #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_ready,
  output logic       frame_err,
  output logic       busy
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
  state_t        r_state;
  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_fclk;
  logic          r_fall;
  logic          r_par_ok;
  logic [FW-1:0] r_fcnt;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_shreg;
  logic [2:0]    r_bit_cnt;
  logic          w_clk_s;
  logic          w_dat_s;
  logic          w_flip;
  logic          w_tmo;
  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];
  // fclk flips on the FILTER_LEN-th consecutive synced sample that disagrees with it
  assign w_flip  = (w_clk_s != r_fclk) && (r_fcnt == FW'(FILTER_LEN - 1));
  // a fall strobe in the same cycle beats the timeout
  assign w_tmo   = (r_state != S_IDLE) && !r_fall && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign busy    = r_state != S_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_fclk     <= 1'b1;
      r_fcnt     <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_dat};
      r_fcnt     <= (w_clk_s == r_fclk || w_flip) ? '0 : r_fcnt + 1'b1;
      r_fclk     <= w_flip ? w_clk_s : r_fclk;
      r_fall     <= w_flip && !w_clk_s;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_tcnt     <= '0;
      r_shreg    <= '0;
      r_par_ok   <= 1'b0;
      scan_code  <= '0;
      scan_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_ready <= 1'b0;
      frame_err  <= 1'b0;
      r_tcnt     <= (r_state == S_IDLE || r_fall || w_tmo) ? '0 : r_tcnt + 1'b1;
      if (w_tmo) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
        r_shreg   <= '0;
        frame_err <= 1'b1;
      end else if (r_fall) begin
        case (r_state)
          S_IDLE: begin
            r_bit_cnt <= '0;
            r_state   <= w_dat_s ? S_IDLE : S_DATA;
          end
          S_DATA: begin
            r_shreg   <= {w_dat_s, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_state   <= (r_bit_cnt == 3'd7) ? S_PARITY : S_DATA;
          end
          S_PARITY: begin
            r_par_ok <= ^r_shreg ^ w_dat_s;
            r_state  <= S_STOP;
          end
          S_STOP: begin
            scan_code  <= (w_dat_s && r_par_ok) ? r_shreg : scan_code;
            scan_ready <= w_dat_s && r_par_ok;
            frame_err  <= !(w_dat_s && r_par_ok);
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb_ps2_rx_ctrl: directed PS/2 frames against a frame-level model of the receiver.
module tb_ps2_rx_ctrl;
  localparam int TMO  = 2000;
  localparam int HALF = 40;
  localparam int LAT  = 11;
  typedef struct {int at; int kind; logic [7:0] code;} ev_t;
  logic       clk = 0;
  logic       rst = 1;
  logic       ps2_clk = 1;
  logic       ps2_dat = 1;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic       frame_err;
  logic       busy;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  ev_t        q[$];
  ev_t        e;
  logic       m_active = 0;
  int         m_n = 0;
  int         m_last = 0;
  logic       m_bits[10];
  logic       exp_busy = 0;
  logic       exp_rdy = 0;
  logic       exp_err = 0;
  logic [7:0] exp_code = 0;
  int         n_rdy = 0;
  int         n_err = 0;
  logic [7:0] rec[$];
  int         n0;

  ps2_rx_ctrl #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .scan_code(scan_code), .scan_ready(scan_ready), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: a pin fall becomes visible LAT cycles later at the outputs.
  task automatic model_fall(input logic b);
    ev_t        ev;
    logic [7:0] d;
    if (!m_active) begin
      if (!b) begin
        m_active = 1;
        m_n = 0;
        m_last = cyc;
        ev.at = cyc + LAT; ev.kind = 0; ev.code = 8'h00;
        q.push_back(ev);
      end
    end else begin
      m_bits[m_n] = b;
      m_n++;
      m_last = cyc;
      if (m_n == 10) begin
        for (int i = 0; i < 8; i++) d[i] = m_bits[i];
        ev.at = cyc + LAT;
        ev.kind = ((($countones(d) + int'(m_bits[8])) % 2 == 1) && m_bits[9]) ? 1 : 2;
        ev.code = d;
        q.push_back(ev);
        m_active = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_busy = 0;
      exp_code = 0;
      q.delete();
    end else begin
      exp_rdy = 0;
      exp_err = 0;
      while (q.size() > 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        if (e.kind == 0) exp_busy = 1;
        else begin
          exp_busy = 0;
          if (e.kind == 1) begin exp_rdy = 1; exp_code = e.code; end
          else exp_err = 1;
        end
      end
      if (m_active && cyc == m_last + LAT + TMO) begin
        exp_err = 1;
        exp_busy = 0;
        m_active = 0;
      end
      chk("scan_ready", scan_ready, exp_rdy);
      chk("frame_err", frame_err, exp_err);
      chk("busy", busy, exp_busy);
      chk("scan_code", scan_code, exp_code);
      if (scan_ready) begin n_rdy++; rec.push_back(scan_code); end
      if (frame_err) n_err++;
    end
  end

  task automatic send_bit(input logic b, input logic glitch);
    repeat (HALF / 2) @(negedge clk);
    ps2_dat = b;
    if (glitch) begin
      repeat (5) @(negedge clk);
      ps2_clk = 0;
      repeat (3) @(negedge clk);
      ps2_clk = 1;
      repeat (3) @(negedge clk);
      ps2_dat = ~b;
      @(negedge clk);
      ps2_dat = b;
      repeat (HALF / 2 - 12) @(negedge clk);
    end else repeat (HALF / 2) @(negedge clk);
    ps2_clk = 0;
    model_fall(b);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop, input int gbit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], gbit == i);
    send_bit((~^d) ^ par_flip, 1'b0);
    send_bit(stop, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_code", scan_code, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", scan_ready, 0);
    chk("rst_err", frame_err, 0);
    rst = 0;
    repeat (10) @(negedge clk);
    send_frame(8'h1D, 0, 1, -1);
    chk("good_1D", scan_code, 8'h1D);
    chk("rdy_cnt_1", n_rdy, 1);
    chk("err_cnt_0", n_err, 0);
    send_frame(8'h1C, 1, 1, -1);
    chk("bad_par_code", scan_code, 8'h1D);
    chk("bad_par_err", n_err, 1);
    chk("bad_par_rdy", n_rdy, 1);
    send_frame(8'h55, 0, 0, -1);
    chk("bad_stop_err", n_err, 2);
    chk("bad_stop_code", scan_code, 8'h1D);
    send_frame(8'h29, 0, 1, -1);
    chk("good_29", scan_code, 8'h29);
    chk("rdy_cnt_2", n_rdy, 2);
    send_bit(0, 0);
    send_bit(1, 0);
    send_bit(0, 0);
    send_bit(1, 0);
    chk("partial_busy", busy, 1);
    repeat (LAT + TMO + 20) @(negedge clk);
    chk("timeout_err", n_err, 3);
    chk("timeout_busy", busy, 0);
    send_frame(8'hF0, 0, 1, -1);
    chk("after_tmo_F0", scan_code, 8'hF0);
    chk("rdy_cnt_3", n_rdy, 3);
    send_frame(8'h3A, 0, 1, 4);
    chk("glitch_3A", scan_code, 8'h3A);
    chk("glitch_err", n_err, 3);
    n0 = rec.size();
    send_frame(8'hE0, 0, 1, -1);
    send_frame(8'hF0, 0, 1, -1);
    send_frame(8'h1D, 0, 1, -1);
    chk("b2b_cnt", rec.size() - n0, 3);
    if (rec.size() >= n0 + 3) begin
      chk("b2b_0", rec[n0], 8'hE0);
      chk("b2b_1", rec[n0 + 1], 8'hF0);
      chk("b2b_2", rec[n0 + 2], 8'h1D);
    end
    send_bit(0, 0);
    send_bit(1, 0);
    send_bit(1, 0);
    send_bit(0, 0);
    send_bit(1, 0);
    rst = 1;
    #1;
    chk("midrst_code", scan_code, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_rdy", scan_ready, 0);
    chk("midrst_err", frame_err, 0);
    m_active = 0;
    repeat (5) @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    send_frame(8'h1B, 0, 1, -1);
    chk("after_rst_1B", scan_code, 8'h1B);
    chk("rdy_cnt_final", n_rdy, 8);
    chk("err_cnt_final", n_err, 3);
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
